// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: steps, jumps, halts and faults the
// instruction-memory address, and owns the start/run/done handshake.
// Optional feature macro: CALL_STACK_EN adds a hardware return-address stack
// for Call/Ret; without it, Call and Ret are ignored.
module pc_fetch_ctrl #(
  parameter int unsigned PC_W        = 12,
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned LAST_ADDR   = 4095,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            Jen,
  input  logic [PC_W-1:0] Jump,
  input  logic            Call,
  input  logic            Ret,
  output logic [PC_W-1:0] Prog_ctr,
  output logic            Running,
  output logic            Done,
  output logic            Fault
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [PC_W-1:0] StartPc = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] LastPc  = PC_W'(LAST_ADDR);

  state_e          state_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W:0]   jump_ext;
  logic            jump_oob;
  logic            run_go;
  logic            ret_req;
  logic            call_req;
  logic            stk_empty;
  logic            stk_full;
  logic [PC_W-1:0] stk_top;

  // Widened compare stays meaningful when LAST_ADDR is the top of the PC range.
  assign pc_inc   = Prog_ctr + PC_W'(1);
  assign jump_ext = {1'b0, Jump};
  assign jump_oob = jump_ext > (PC_W + 1)'(LAST_ADDR);
  assign run_go   = (state_q == StRun) && !Stall;

`ifdef CALL_STACK_EN
  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic [SpW-1:0]  sp_q;
  logic [IdxW-1:0] top_idx;
  logic [IdxW-1:0] push_idx;
  logic            push_en;
  logic            pop_en;
  logic            clear_en;

  // Ret outranks Call when both are strobed.
  assign ret_req   = Ret;
  assign call_req  = Call && !Ret;
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SpW'(STACK_DEPTH));
  assign top_idx   = IdxW'(sp_q - SpW'(1));
  assign push_idx  = IdxW'(sp_q);
  assign stk_top   = stack_q[top_idx];

  assign push_en  = run_go && !Halt && call_req && !stk_full && !jump_oob;
  assign pop_en   = run_go && !Halt && ret_req && !stk_empty;
  assign clear_en = Start && (state_q != StRun);

  // Stack pointer: cleared by reset and by every honoured Start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sp_q <= '0;
    end else if (clear_en) begin
      sp_q <= '0;
    end else if (push_en) begin
      sp_q <= sp_q + SpW'(1);
    end else if (pop_en) begin
      sp_q <= sp_q - SpW'(1);
    end
  end

  // Stack storage holds the return address (call site + 1); needs no reset.
  always_ff @(posedge Clk) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end
`else
  logic unused_call_ret;

  assign unused_call_ret = Call ^ Ret;
  assign ret_req   = 1'b0;
  assign call_req  = 1'b0;
  assign stk_empty = 1'b1;
  assign stk_full  = 1'b0;
  assign stk_top   = StartPc;
`endif

  logic            run_end;
  logic            run_fault;
  logic [PC_W-1:0] run_pc;

  // Decode one unstalled RUN cycle in priority order: Halt, Ret, Call, Jen, step.
  always_comb begin
    run_end   = 1'b0;
    run_fault = 1'b0;
    run_pc    = Prog_ctr;
    if (Halt) begin
      run_end = 1'b1;
    end else if (ret_req) begin
      if (stk_empty) begin
        run_end   = 1'b1;
        run_fault = 1'b1;
      end else begin
        run_pc = stk_top;
      end
    end else if (call_req) begin
      if (stk_full || jump_oob) begin
        run_end   = 1'b1;
        run_fault = 1'b1;
      end else begin
        run_pc = Jump;
      end
    end else if (Jen) begin
      if (jump_oob) begin
        run_end   = 1'b1;
        run_fault = 1'b1;
      end else begin
        run_pc = Jump;
      end
    end else if (Prog_ctr == LastPc) begin
      run_end = 1'b1;
    end else begin
      run_pc = pc_inc;
    end
  end

  // Control FSM with registered PC and status outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      Prog_ctr <= StartPc;
      Running  <= 1'b0;
      Done     <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            state_q  <= StRun;
            Prog_ctr <= StartPc;
            Running  <= 1'b1;
            Done     <= 1'b0;
            Fault    <= 1'b0;
          end
        end
        StRun: begin
          if (!Stall) begin
            Prog_ctr <= run_pc;
            if (run_end) begin
              state_q <= StDone;
              Running <= 1'b0;
              Done    <= 1'b1;
              Fault   <= run_fault;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a default-range instance and one with
// LAST_ADDR=10; expectations queue up as stimulus is driven and are popped
// once the DUT has produced the corresponding output.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, stall, halt, jen, call, ret;
  logic [11:0] jump;
  logic [11:0] pc;
  logic        running, done, fault;

  logic        start_b, jen_b, call_b;
  logic [11:0] jump_b;
  logic [11:0] pc_b;
  logic        running_b, done_b, fault_b;

  pc_fetch_ctrl u_dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .Start    (start),
    .Stall    (stall),
    .Halt     (halt),
    .Jen      (jen),
    .Jump     (jump),
    .Call     (call),
    .Ret      (ret),
    .Prog_ctr (pc),
    .Running  (running),
    .Done     (done),
    .Fault    (fault)
  );

  pc_fetch_ctrl #(.LAST_ADDR(10)) u_dut10 (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .Start    (start_b),
    .Stall    (1'b0),
    .Halt     (1'b0),
    .Jen      (jen_b),
    .Jump     (jump_b),
    .Call     (call_b),
    .Ret      (1'b0),
    .Prog_ctr (pc_b),
    .Running  (running_b),
    .Done     (done_b),
    .Fault    (fault_b)
  );

  typedef struct {
    string       tag;
    bit          sel_b;
    logic [14:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push_exp(input string tag, input bit sel_b, input logic [11:0] epc,
                          input logic erun, input logic edone, input logic efault);
    exp_t e;
    e.tag   = tag;
    e.sel_b = sel_b;
    e.v     = {epc, erun, edone, efault};
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t        e;
    logic [14:0] obs;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard: observed empty queue, expected a pending entry");
    end else begin
      e   = sb.pop_front();
      obs = e.sel_b ? {pc_b, running_b, done_b, fault_b} : {pc, running, done, fault};
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed pc=%0d run=%b done=%b fault=%b, expected pc=%0d run=%b done=%b fault=%b",
               e.tag, obs[14:3], obs[2], obs[1], obs[0], e.v[14:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  endtask

  // Expectation for the current (unclocked) output values.
  task automatic now(input string tag, input bit sel_b, input logic [11:0] epc,
                     input logic erun, input logic edone, input logic efault);
    push_exp(tag, sel_b, epc, erun, edone, efault);
    check_front();
  endtask

  // Expectation for the outputs after the next rising edge.
  task automatic step(input string tag, input bit sel_b, input logic [11:0] epc,
                      input logic erun, input logic edone, input logic efault);
    push_exp(tag, sel_b, epc, erun, edone, efault);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; stall = 1'b0; halt = 1'b0; jen = 1'b0; call = 1'b0; ret = 1'b0;
    jump = '0;
    start_b = 1'b0; jen_b = 1'b0; call_b = 1'b0; jump_b = '0;

    #1;
    now("reset", 0, 12'd0, 1'b0, 1'b0, 1'b0);
    now("reset_b", 1, 12'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_ignores", 0, 12'd0, 1'b0, 1'b0, 1'b0);

    // Start and sequential fetch.
    start = 1'b1;
    step("start", 0, 12'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) step("seq", 0, 12'(i), 1'b1, 1'b0, 1'b0);

    // Jumps, and Stall overriding a jump.
    jen = 1'b1; jump = 12'd7;
    step("jmp7", 0, 12'd7, 1'b1, 1'b0, 1'b0);
    jump = 12'd92; stall = 1'b1;
    step("stall_jmp", 0, 12'd7, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    step("jmp92", 0, 12'd92, 1'b1, 1'b0, 1'b0);
    jump = 12'd241;
    step("jmp241", 0, 12'd241, 1'b1, 1'b0, 1'b0);
    jen = 1'b0;

    // Halt, hold in DONE, restart; Start in RUN is ignored.
    halt = 1'b1;
    step("halt", 0, 12'd241, 1'b0, 1'b1, 1'b0);
    halt = 1'b0;
    step("done_hold", 0, 12'd241, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    step("restart", 0, 12'd0, 1'b1, 1'b0, 1'b0);
    step("start_in_run", 0, 12'd1, 1'b1, 1'b0, 1'b0);
    start = 1'b0;

    // End of program at the top of the address range: no wrap.
    jen = 1'b1; jump = 12'd4094;
    step("jmp4094", 0, 12'd4094, 1'b1, 1'b0, 1'b0);
    jen = 1'b0;
    step("step4095", 0, 12'd4095, 1'b1, 1'b0, 1'b0);
    step("eop", 0, 12'd4095, 1'b0, 1'b1, 1'b0);
    step("eop_hold", 0, 12'd4095, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    step("start2", 0, 12'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;

`ifdef CALL_STACK_EN
    jen = 1'b1; jump = 12'd5;
    step("jmp5", 0, 12'd5, 1'b1, 1'b0, 1'b0);
    jen = 1'b0; call = 1'b1; jump = 12'd80;
    step("call80", 0, 12'd80, 1'b1, 1'b0, 1'b0);
    call = 1'b0;
    step("sub81", 0, 12'd81, 1'b1, 1'b0, 1'b0);
    step("sub82", 0, 12'd82, 1'b1, 1'b0, 1'b0);
    ret = 1'b1;
    step("ret6", 0, 12'd6, 1'b1, 1'b0, 1'b0);
    ret = 1'b0;
    call = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      jump = 12'(i * 100);
      step("nest_call", 0, 12'(i * 100), 1'b1, 1'b0, 1'b0);
    end
    jump = 12'd500;
    step("call_ovf", 0, 12'd400, 1'b0, 1'b1, 1'b1);
    call = 1'b0;
    start = 1'b1;
    step("start_clr", 0, 12'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0; ret = 1'b1;
    step("ret_unf", 0, 12'd0, 1'b0, 1'b1, 1'b1);
    ret = 1'b0; start = 1'b1;
    step("start3", 0, 12'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
`else
    call = 1'b1; jump = 12'd80;
    step("call_ignored", 0, 12'd1, 1'b1, 1'b0, 1'b0);
    call = 1'b0; ret = 1'b1;
    step("ret_ignored", 0, 12'd2, 1'b1, 1'b0, 1'b0);
    ret = 1'b0;
`endif

    // Short program (LAST_ADDR=10): natural end and out-of-range jumps.
    start_b = 1'b1;
    step("b_start", 1, 12'd0, 1'b1, 1'b0, 1'b0);
    start_b = 1'b0;
    for (int i = 1; i <= 10; i++) step("b_seq", 1, 12'(i), 1'b1, 1'b0, 1'b0);
    step("b_eop", 1, 12'd10, 1'b0, 1'b1, 1'b0);
    step("b_eop_hold", 1, 12'd10, 1'b0, 1'b1, 1'b0);
    start_b = 1'b1;
    step("b_restart", 1, 12'd0, 1'b1, 1'b0, 1'b0);
    start_b = 1'b0; jen_b = 1'b1; jump_b = 12'd11;
    step("b_jmp_oob", 1, 12'd0, 1'b0, 1'b1, 1'b1);
    jen_b = 1'b0;
    step("b_fault_hold", 1, 12'd0, 1'b0, 1'b1, 1'b1);
    start_b = 1'b1;
    step("b_fault_clr", 1, 12'd0, 1'b1, 1'b0, 1'b0);
    start_b = 1'b0; jen_b = 1'b1; jump_b = 12'd10;
    step("b_jmp_last", 1, 12'd10, 1'b1, 1'b0, 1'b0);
    jump_b = 12'd11;
    step("b_jmp_oob2", 1, 12'd10, 1'b0, 1'b1, 1'b1);
    jen_b = 1'b0;
`ifdef CALL_STACK_EN
    start_b = 1'b1;
    step("b_restart2", 1, 12'd0, 1'b1, 1'b0, 1'b0);
    start_b = 1'b0; call_b = 1'b1; jump_b = 12'd11;
    step("b_call_oob", 1, 12'd0, 1'b0, 1'b1, 1'b1);
    call_b = 1'b0;
`endif

    // Asynchronous reset in the middle of RUN.
    jen = 1'b1; jump = 12'd50;
    step("jmp50", 0, 12'd50, 1'b1, 1'b0, 1'b0);
    jen = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    now("async_rst", 0, 12'd0, 1'b0, 1'b0, 1'b0);
    now("async_rst_b", 1, 12'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_idle", 0, 12'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-sequencing stage for the core. It consumes the 12-bit absolute target produced by the jump lookup table and the decoder's control strobes, and drives the instruction-memory address. It owns the start/run/done handshake with the testbench, and optionally a small hardware return-address stack for call/return.

## Interface
Parameters:
- PC_W, 12: program-counter width; matches the jump-table target width.
- START_ADDR, 0: address loaded on reset and on every Start.
- LAST_ADDR, 4095: highest legal instruction address; sequential step past it ends the program.
- STACK_DEPTH, 4: return-stack entries (used only with CALL_STACK_EN).

Ports:
- Clk  in  1  single clock, rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  begin execution at START_ADDR; honoured in IDLE and DONE only.
- Stall  in  1  hold PC and state this cycle.
- Halt  in  1  decoded halt instruction at current PC.
- Jen  in  1  taken absolute jump; target is Jump.
- Jump  in  PC_W  target from the jump lookup table, valid in the same cycle as Jen/Call.
- Call  in  1  call: push return address, go to Jump (CALL_STACK_EN only).
- Ret  in  1  return: pop return address (CALL_STACK_EN only).
- Prog_ctr  out  PC_W  instruction-memory address, registered.
- Running  out  1  high while in RUN.
- Done  out  1  level, high in DONE.
- Fault  out  1  sticky error flag, cleared by Start.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, Prog_ctr=START_ADDR, Running=0, Done=0, Fault=0, stack pointer=0.
- IDLE: Start → RUN, Prog_ctr=START_ADDR. Other inputs ignored.
- RUN, per cycle, in priority order:
  - Stall: no change to PC, state, or stack.
  - Halt: → DONE, PC holds.
  - Ret (macro on): pop into PC; if stack empty → Fault=1, DONE, PC holds.
  - Call (macro on): if stack full → Fault=1, DONE; else push Prog_ctr+1, PC=Jump.
  - Jen: if Jump > LAST_ADDR → Fault=1, DONE, PC holds; else PC=Jump.
  - Otherwise: if Prog_ctr == LAST_ADDR → DONE, PC holds (no wrap); else PC=Prog_ctr+1.
- Call and Jen together: Call wins (both use Jump).
- Call with Jump > LAST_ADDR: Fault, DONE, no push.
- DONE: Done=1, PC holds. Start → RUN at START_ADDR, clears Done, Fault, and the stack.
- Start in RUN is ignored.
- Arithmetic: PC_W-bit unsigned; the increment never wraps because LAST_ADDR terminates the program.

## Timing
- All outputs are registered. Inputs are sampled on a rising edge, and the effect is visible after that edge (1-cycle latency).
- Jump is combinational from the lookup table and must be stable in the cycle Jen/Call is high.
- Running rises the cycle after Start. Done rises the cycle after the terminating edge (Halt, end of program, or fault).
- Reset_n low at any time, including mid-RUN, immediately forces the reset values. Deassertion must be synchronous to Clk.

## Configuration
- CALL_STACK_EN defined:
  - STACK_DEPTH-entry return-address stack of PC_W-bit entries.
  - Call/Ret are honoured, with overflow and underflow faults as above.
- CALL_STACK_EN undefined:
  - No stack storage; Call and Ret are ignored (treated as 0).
  - Fault is raised only for an out-of-range Jen target.

## Test plan
- Reset, Start, 5 idle cycles → Prog_ctr 0,1,2,3,4,5; Running=1 from the cycle after Start; Done=0.
- RUN at PC=7, Jen=1, Jump=92 → next Prog_ctr=92; with Stall=1 the same cycle → PC stays 7.
- Halt at PC=241 → Done=1 next cycle, Prog_ctr stays 241; Start → Prog_ctr=0, Done=0.
- LAST_ADDR=10, no jumps → PC counts to 10, then Done=1, PC stays 10. Jen with Jump=11 → Fault=1, Done=1.
- CALL_STACK_EN: Call at PC=5 with Jump=80, then Ret at PC=82 → PC 80, 81, 82, 6. Five nested Calls with depth 4 → Fault on the fifth. Ret with an empty stack → Fault.
- Reset_n pulsed low mid-RUN at PC=50 → outputs reset without waiting for a Clk edge: Prog_ctr=0, Running=0, Done=0, Fault=0.
